// File: rtl/mips.sv
// ---------------------------------------------------------------------------
// mips: single-cycle 32-bit MIPS core (controller + datapath).
//
// Each instruction is fetched, decoded, executed and committed within one
// clock cycle. Instruction and data memories live outside this block.
//
// Ports
//   clk        in   1  rising-edge clock
//   reset      in   1  synchronous, active-high; clears pc and all registers
//   pc         out 32  current fetch address (registered)
//   instr      in  32  instruction at pc (combinational imem)
//   memwrite   out  1  data-memory write enable (SW only)
//   aluout     out 32  ALU result, also the data-memory address
//   writedata  out 32  R[rt], the store data for SW
//   readdata   in  32  data-memory read value at aluout (LW)
// ---------------------------------------------------------------------------
module mips (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] instr,
    output logic        memwrite,
    output logic [31:0] aluout,
    output logic [31:0] writedata,
    input  logic [31:0] readdata
);

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [1:0] {
        AOP_ADD   = 2'b00,
        AOP_SUB   = 2'b01,
        AOP_FUNCT = 2'b10
    } aluop_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_ctrl_e;

    // -----------------------------------------------------------------------
    // Instruction fields
    // -----------------------------------------------------------------------
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] jaddr;
    logic        unused_shamt;

    assign op           = instr[31:26];
    assign rs           = instr[25:21];
    assign rt           = instr[20:16];
    assign rd           = instr[15:11];
    assign funct        = instr[5:0];
    assign imm          = instr[15:0];
    assign jaddr        = instr[25:0];
    assign unused_shamt = ^instr[10:6];

    // -----------------------------------------------------------------------
    // Main decoder
    // -----------------------------------------------------------------------
    logic   is_rtype;
    logic   regdst;
    logic   alusrc;
    logic   memtoreg;
    logic   branch;
    logic   jump;
    logic   dec_memwrite;
    logic   dec_regwrite;
    aluop_e aluop;

    always_comb begin
        is_rtype     = 1'b0;
        regdst       = 1'b0;
        alusrc       = 1'b0;
        memtoreg     = 1'b0;
        branch       = 1'b0;
        jump         = 1'b0;
        dec_memwrite = 1'b0;
        dec_regwrite = 1'b0;
        aluop        = AOP_ADD;
        case (op)
            OP_RTYPE: begin
                is_rtype     = 1'b1;
                regdst       = 1'b1;
                dec_regwrite = 1'b1;
                aluop        = AOP_FUNCT;
            end
            OP_LW: begin
                alusrc       = 1'b1;
                memtoreg     = 1'b1;
                dec_regwrite = 1'b1;
            end
            OP_SW: begin
                alusrc       = 1'b1;
                dec_memwrite = 1'b1;
            end
            OP_BEQ: begin
                branch = 1'b1;
                aluop  = AOP_SUB;
            end
            OP_ADDI: begin
                alusrc       = 1'b1;
                dec_regwrite = 1'b1;
            end
            OP_J: begin
                jump = 1'b1;
            end
            default: ;  // unknown opcode: NOP
        endcase
    end

    // -----------------------------------------------------------------------
    // ALU decoder; funct_ok gates the register write so an unlisted R-type
    // funct degrades to a NOP.
    // -----------------------------------------------------------------------
    alu_ctrl_e alu_ctrl;
    logic      funct_ok;

    always_comb begin
        alu_ctrl = ALU_ADD;
        funct_ok = 1'b1;
        case (aluop)
            AOP_ADD: alu_ctrl = ALU_ADD;
            AOP_SUB: alu_ctrl = ALU_SUB;
            default: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: funct_ok = 1'b0;
                endcase
            end
        endcase
    end

    logic regwrite;
    assign regwrite = dec_regwrite & (~is_rtype | funct_ok);
    assign memwrite = dec_memwrite;

    // -----------------------------------------------------------------------
    // Register file: two combinational read ports, R0 hard-wired to zero
    // -----------------------------------------------------------------------
    logic [31:0] rf_q [32];
    logic [31:0] rd1;
    logic [31:0] rd2;

    assign rd1       = (rs == 5'd0) ? 32'd0 : rf_q[rs];
    assign rd2       = (rt == 5'd0) ? 32'd0 : rf_q[rt];
    assign writedata = rd2;

    // -----------------------------------------------------------------------
    // ALU (two's complement, wrap-around)
    // -----------------------------------------------------------------------
    logic signed [31:0] imm_sext;
    logic signed [31:0] src_a;
    logic signed [31:0] src_b;
    logic signed [31:0] alu_res;

    assign imm_sext = {{16{imm[15]}}, imm};
    assign src_a    = rd1;
    assign src_b    = alusrc ? imm_sext : rd2;

    always_comb begin
        alu_res = src_a + src_b;
        case (alu_ctrl)
            ALU_ADD: alu_res = src_a + src_b;
            ALU_SUB: alu_res = src_a - src_b;
            ALU_AND: alu_res = src_a & src_b;
            ALU_OR:  alu_res = src_a | src_b;
            ALU_SLT: alu_res = (src_a < src_b) ? 32'sd1 : 32'sd0;
            default: alu_res = src_a + src_b;
        endcase
    end

    assign aluout = alu_res;

    // -----------------------------------------------------------------------
    // Write-back selection
    // -----------------------------------------------------------------------
    logic [4:0]  waddr;
    logic [31:0] wdata;

    assign waddr = regdst ? rd : rt;
    assign wdata = memtoreg ? readdata : aluout;

    // -----------------------------------------------------------------------
    // Next PC: jump beats branch; the branch offset is relative to pc + 4
    // -----------------------------------------------------------------------
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] pc_branch;
    logic        zero;

    assign pc_plus4  = pc_q + 32'd4;
    assign pc_branch = pc_plus4 + (imm_sext <<< 2);
    assign zero      = (aluout == 32'd0);

    always_comb begin
        pc_d = pc_plus4;
        if (jump)
            pc_d = {pc_plus4[31:28], jaddr, 2'b00};
        else if (branch && zero)
            pc_d = pc_branch;
    end

    assign pc = pc_q;

    // -----------------------------------------------------------------------
    // State update; reset suppresses both the PC step and the register write
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= 32'd0;
            for (int i = 0; i < 32; i++)
                rf_q[i] <= 32'd0;
        end else begin
            pc_q <= pc_d;
            if (regwrite && (waddr != 5'd0))
                rf_q[waddr] <= wdata;
        end
    end

endmodule

// File: tb/tb_mips.sv
// ---------------------------------------------------------------------------
// tb_mips: scoreboard bench for the single-cycle mips core. The driver
// presents one instruction per cycle and queues what the combinational
// outputs must show during that cycle; the monitor pops and compares on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_mips;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;

    mips dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .instr     (instr),
        .memwrite  (memwrite),
        .aluout    (aluout),
        .writedata (writedata),
        .readdata  (readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        bit          chk_alu;
        logic [31:0] alu;
        bit          chk_wd;
        logic [31:0] wd;
        logic        mw;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] jtype(input logic [25:0] a);
        return {6'h02, a};
    endfunction

    // Drive one instruction just after the rising edge and queue its expectations.
    task automatic step(input string tag, input logic [31:0] ins, input logic [31:0] rdata,
                        input logic [31:0] exp_pc, input bit ca, input logic [31:0] alu,
                        input bit cw, input logic [31:0] wd, input logic mw, input logic rst);
        exp_t e;
        @(posedge clk);
        #1;
        reset    = rst;
        instr    = ins;
        readdata = rdata;
        e.tag = tag; e.pc = exp_pc; e.chk_alu = ca; e.alu = alu;
        e.chk_wd = cw; e.wd = wd; e.mw = mw;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, ".pc"}, pc, e.pc);
            check({e.tag, ".memwrite"}, {31'd0, memwrite}, {31'd0, e.mw});
            if (e.chk_alu) check({e.tag, ".aluout"}, aluout, e.alu);
            if (e.chk_wd)  check({e.tag, ".writedata"}, writedata, e.wd);
        end
    end

    initial begin
        // Reset edge with a register-writing instruction present: it must not commit.
        reset    = 1'b1;
        instr    = itype(6'h08, 5'd0, 5'd1, 16'h0077);
        readdata = 32'd0;

        step("rst_add",  rtype(0, 0, 9, 6'h20),        0, 32'h00, 1, 32'd0,        0, 0, 0, 0);
        step("addi_r1",  itype(6'h08, 0, 1, 16'd5),    0, 32'h04, 1, 32'd5,        0, 0, 0, 0);
        step("sub",      rtype(1, 1, 2, 6'h22),        0, 32'h08, 1, 32'd0,        0, 0, 0, 0);
        step("and",      rtype(1, 1, 3, 6'h24),        0, 32'h0C, 1, 32'd5,        0, 0, 0, 0);
        step("or",       rtype(1, 1, 4, 6'h25),        0, 32'h10, 1, 32'd5,        0, 0, 0, 0);
        step("slt_10",   rtype(1, 0, 5, 6'h2A),        0, 32'h14, 1, 32'd0,        0, 0, 0, 0);
        step("slt_01",   rtype(0, 1, 5, 6'h2A),        0, 32'h18, 1, 32'd1,        0, 0, 0, 0);
        step("addi_m1",  itype(6'h08, 0, 10, 16'hFFFF),0, 32'h1C, 1, 32'hFFFFFFFF, 0, 0, 0, 0);
        step("slt_sgn",  rtype(10, 0, 11, 6'h2A),      0, 32'h20, 1, 32'd1,        0, 0, 0, 0);
        step("rd_r11",   rtype(11, 0, 12, 6'h20),      0, 32'h24, 1, 32'd1,        0, 0, 0, 0);
        step("lw",       itype(6'h23, 0, 6, 16'd0), 32'h10, 32'h28, 1, 32'd0,      0, 0, 0, 0);
        step("sw",       itype(6'h2B, 0, 6, 16'd4),    0, 32'h2C, 1, 32'd4,     1, 32'h10, 1, 0);
        step("after_sw", rtype(0, 0, 9, 6'h20),        0, 32'h30, 1, 32'd0,        0, 0, 0, 0);
        step("addi_r7",  itype(6'h08, 0, 7, 16'd5),    0, 32'h34, 1, 32'd5,        0, 0, 0, 0);
        step("addi_r8",  itype(6'h08, 0, 8, 16'd5),    0, 32'h38, 1, 32'd5,        0, 0, 0, 0);
        step("addi_r0",  itype(6'h08, 0, 0, 16'd7),    0, 32'h3C, 1, 32'd7,        0, 0, 0, 0);
        step("j",        jtype(26'h0000002),           0, 32'h40, 0, 0,            0, 0, 0, 0);
        step("r0_zero",  rtype(0, 1, 13, 6'h20),       0, 32'h08, 1, 32'd5,        0, 0, 0, 0);
        step("beq_tk",   itype(6'h04, 7, 8, 16'd2),    0, 32'h0C, 1, 32'd0,        0, 0, 0, 0);
        step("addi_r8b", itype(6'h08, 0, 8, 16'd6),    0, 32'h18, 1, 32'd6,        0, 0, 0, 0);
        step("beq_nt",   itype(6'h04, 7, 8, 16'd2),    0, 32'h1C, 1, 32'hFFFFFFFF, 0, 0, 0, 0);
        step("beq_self", itype(6'h04, 0, 0, 16'hFFFF), 0, 32'h20, 1, 32'd0,        0, 0, 0, 0);
        step("illegal",  itype(6'h3F, 0, 1, 16'hFFFF), 0, 32'h20, 0, 0,           0, 0, 0, 0);
        step("r1_kept",  rtype(1, 0, 14, 6'h20),       0, 32'h24, 1, 32'd5,        0, 0, 0, 0);
        step("bad_fn",   rtype(1, 1, 1, 6'h21),        0, 32'h28, 0, 0,            0, 0, 0, 0);
        step("r1_kept2", rtype(1, 0, 14, 6'h20),       0, 32'h2C, 1, 32'd5,        0, 0, 0, 0);
        step("sw_r7",    itype(6'h2B, 1, 7, 16'd8),    0, 32'h30, 1, 32'h0D,    1, 32'd5, 1, 0);
        // Mid-program reset: the ADDI in flight must not commit.
        step("rst_mid",  itype(6'h08, 0, 1, 16'd9),    0, 32'h34, 1, 32'd9,        0, 0, 0, 1);
        step("post_r1",  rtype(1, 0, 15, 6'h20),       0, 32'h00, 1, 32'd0,        0, 0, 0, 0);
        step("post_r6",  rtype(6, 0, 15, 6'h20),       0, 32'h04, 1, 32'd0,        0, 0, 0, 0);

        // Wait (bounded) for the monitor to drain the scoreboard.
        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(posedge clk);
        if (sb.size() > 0)
            check("sb_drain", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
